// File: rtl/uart_tx_bank.sv
// Bank of UART transmit lines sharing one 8N1 shift engine; a byte is sent on
// whichever single channel uart_en selects at the moment it is accepted.
module uart_tx_bank #(
  parameter int CHANNEL_AMOUNT = 8,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNEL_AMOUNT-1:0] uart_en,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [CHANNEL_AMOUNT-1:0] tx,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CH_W  = (CHANNEL_AMOUNT > 1) ? $clog2(CHANNEL_AMOUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                    r_state,  w_state_nxt;
  logic [CNT_W-1:0]          r_cnt,    w_cnt_nxt;
  logic [2:0]                r_bit,    w_bit_nxt;
  logic [7:0]                r_shift,  w_shift_nxt;
  logic [CH_W-1:0]           r_ch,     w_ch_nxt;
  logic [CHANNEL_AMOUNT-1:0] r_tx,     w_tx_nxt;
  logic                      r_busy,   w_busy_nxt;
  logic                      r_done,   w_done_nxt;

  logic                      w_en_onehot;
  logic [CH_W-1:0]           w_sel_idx;
  logic                      w_bit_end;
  logic                      w_line_nxt;
  logic                      w_accept;

  // A zero or multi-hot select stalls the upstream instead of guessing a channel.
  assign w_en_onehot = (uart_en != '0) && ((uart_en & (uart_en - 1'b1)) == '0);
  assign tx_ready    = (r_state == IDLE) && w_en_onehot;
  assign w_accept    = tx_valid && tx_ready;
  assign w_bit_end   = (r_cnt == CNT_LAST);

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < CHANNEL_AMOUNT; i++) begin
      if (uart_en[i]) w_sel_idx = CH_W'(i);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_ch_nxt    = r_ch;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_line_nxt  = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = tx_data;
          w_ch_nxt    = w_sel_idx;
          w_busy_nxt  = 1'b1;
          w_line_nxt  = 1'b0;
        end
      end

      START: begin
        w_line_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_line_nxt  = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DATA: begin
        w_line_nxt = r_shift[0];
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
            w_line_nxt  = 1'b1;
          end else begin
            // The next data bit is presented on the same edge the shifter advances.
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_line_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Only the captured channel ever carries the frame; every other line stays idle high.
  always_comb begin
    w_tx_nxt           = '1;
    w_tx_nxt[w_ch_nxt] = w_line_nxt;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ch    <= '0;
      r_tx    <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_ch    <= w_ch_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: doc/uart_tx_bank.md
UART_TX_BANK -- requirements
Module: uart_tx_bank

Interface
REQ-001 SHALL have parameter CHANNEL_AMOUNT, default 8: number of UART output channels.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per UART bit, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port uart_en, input, CHANNEL_AMOUNT bits: channel select from the upstream selector, synchronous to clk, one-hot or zero.
REQ-006 SHALL have port tx_data, input, 8 bits: byte to transmit.
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data holds a byte to send.
REQ-008 SHALL have port tx_ready, output, 1 bit: block will accept a byte this cycle.
REQ-009 SHALL have port tx, output, CHANNEL_AMOUNT bits: per-channel serial lines, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP with a single shared shift engine.
REQ-013 SHALL drive tx_ready combinationally as (state == IDLE) AND (uart_en has exactly one bit set).
REQ-014 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both 1, capturing tx_data and the uart_en channel index.
REQ-015 SHALL drop nothing and accept nothing while uart_en is zero or multi-hot; tx_valid is then held by the upstream, and no tx line changes.
REQ-016 SHALL enter START on the edge of acceptance, driving the captured channel's tx low from the next cycle for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL in DATA send 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index that ends at 7.
REQ-018 SHALL in STOP drive tx high for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 SHALL keep total frame length at exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to IDLE.
REQ-020 SHALL hold every non-captured channel's tx at 1 for the whole frame.
REQ-021 SHALL ignore uart_en and tx_data changes after acceptance until the frame completes.
REQ-022 SHALL pulse frame_done for one cycle, the first cycle back in IDLE; tx_ready may be 1 in that same cycle, allowing back-to-back frames with no idle bit-time.
REQ-023 SHALL assert busy, registered, in START, DATA and STOP and deassert it in IDLE.
REQ-024 SHALL use a baud counter of width clog2(CLKS_PER_BIT), counting 0 to CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.
REQ-025 SHALL register all tx outputs so that no combinational glitch appears on any line.

Reset
REQ-026 SHALL, while reset is 0, force state IDLE, tx all 1s, busy 0, frame_done 0, and clear the counters, the bit index and the captured channel, independent of clk.
REQ-027 SHALL abort any frame in progress when reset asserts mid-frame, returning the line high immediately, with no frame_done pulse.
REQ-028 SHALL start operating on the first rising clk edge after reset deasserts.

Verification (CLKS_PER_BIT=4, CHANNEL_AMOUNT=8)
REQ-029 SHALL cover: uart_en=8'h04, tx_valid with 8'hA5 -> tx[2] sends 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; other lines stay 1; frame_done pulses after 40 cycles.
REQ-030 SHALL cover: uart_en=8'h00 or 8'h03 with tx_valid=1 -> tx_ready=0, no acceptance, all tx stay 1, busy stays 0.
REQ-031 SHALL cover: uart_en changes 8'h01->8'h80 mid-frame -> the frame completes on tx[0]; tx[7] stays 1.
REQ-032 SHALL cover: back-to-back 8'h00 then 8'hFF on channel 5 -> second start bit begins the cycle after frame_done; total 80 cycles.
REQ-033 SHALL cover: reset asserted in the fourth data bit -> tx returns to 8'hFF asynchronously, busy=0, no frame_done; the next frame after release is correct.
